// File: rtl/pipe_if_fq_pkg.sv
// Shared RISC-V opcode constants and fetch FSM state encoding.
// Latency: n/a (constants, types and a pure helper function).
// Backpressure: n/a.
package pipe_if_fq_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Memory read length code for a full 32-bit word.
  localparam logic [1:0] MEM_RLEN_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_st_e;

  // True for opcodes that change control flow and may park the fetcher.
  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: DEPTH-entry FIFO of {pc, instruction} words with flush.
// Latency: a pushed word is visible at the head in the cycle after the push.
// Backpressure: full_o blocks pushes (never overwrites); flush beats push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Head reads as zero when empty so stale entries never leak out.
  assign dat_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush drops every entry, including one being popped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= dat_i;
  end

endmodule

// File: rtl/pipe_if_fq.sv
// Instruction fetch unit: one outstanding word read feeding a fetch queue.
// Latency: mem_rack in cycle n gives inst_valid in cycle n+1 on an empty queue.
// Backpressure: inst_ready stalls the queue; fetch stops issuing while the queue is full.
module pipe_if_fq
  import pipe_if_fq_pkg::*;
#(
  parameter int              INST_L        = 32,
  parameter int              PC_L          = 32,
  parameter int              FQ_DEPTH      = 4,
  parameter logic [PC_L-1:0] PC_ENTRY      = 32'h00000000,
  parameter int              STALL_ON_CTRL = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_re,
  output logic [PC_L-1:0]   mem_addr,
  output logic [1:0]        mem_rlen,
  input  logic              mem_rack,
  input  logic [INST_L-1:0] mem_data,
  output logic              inst_valid,
  output logic [INST_L-1:0] inst,
  output logic [PC_L-1:0]   inst_pc,
  input  logic              inst_ready,
  input  logic              jp_e,
  input  logic [PC_L-1:0]   jp_pc,
  output logic              jp_ack,
  output logic [9:0]        bp_tag_q,
  output logic              halt
);

  fetch_st_e         state_q;
  logic [PC_L-1:0]   pc_q;
  logic [PC_L-1:0]   mem_addr_q;
  logic              mem_re_q, discard_q, jp_ack_q, halt_q;

  logic              redir, take_word, fq_push, fq_pop, fq_full, fq_empty;
  logic [PC_L+INST_L-1:0] fq_dat;

  // A non-zero redirect target flushes and repoints fetch anywhere but HALT.
  assign redir     = jp_e && (jp_pc != '0) && (state_q != ST_HALT);
  // A returning word is used only if no redirect overrides it and it is not stale.
  assign take_word = (state_q == ST_WAIT) && mem_rack && !discard_q && !redir;
  assign fq_push   = take_word && (mem_data != '0);
  assign fq_pop    = inst_ready && !fq_empty;

  assign mem_re     = mem_re_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rlen   = MEM_RLEN_WORD;
  assign jp_ack     = jp_ack_q;
  assign halt       = halt_q;
  assign inst_valid = !fq_empty;
  assign {inst_pc, inst} = fq_dat;

  fetch_fifo #(
    .WIDTH (PC_L + INST_L),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fq_push),
    .pop_i   (fq_pop),
    .flush_i (redir),
    .dat_i   ({pc_q, mem_data}),
    .dat_o   (fq_dat),
    .full_o  (fq_full),
    .empty_o (fq_empty)
  );

  // Fetch FSM with registered request, acknowledge, tag and halt outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= PC_ENTRY;
      mem_addr_q <= PC_ENTRY;
      mem_re_q   <= 1'b0;
      discard_q  <= 1'b0;
      jp_ack_q   <= 1'b0;
      bp_tag_q   <= '0;
      halt_q     <= 1'b0;
    end else begin
      jp_ack_q <= jp_e;
      case (state_q)
        ST_FETCH: begin
          if (redir) begin
            pc_q <= jp_pc;
          end else if (!fq_full) begin
            mem_re_q   <= 1'b1;
            mem_addr_q <= pc_q;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rack) begin
            mem_re_q  <= 1'b0;
            discard_q <= 1'b0;
            if (redir) begin
              pc_q    <= jp_pc;
              state_q <= ST_FETCH;
            end else if (discard_q) begin
              // Stale word from before a redirect: drop it, pc already retargeted.
              state_q <= ST_FETCH;
            end else if (mem_data == '0) begin
              halt_q  <= 1'b1;
              state_q <= ST_HALT;
            end else begin
              pc_q <= pc_q + PC_L'(4);
              if (mem_data[6:0] == OP_BRANCH) bp_tag_q <= pc_q[9:0];
              if ((STALL_ON_CTRL != 0) && is_ctrl_op(mem_data[6:0])) state_q <= ST_HOLD;
              else                                                   state_q <= ST_FETCH;
            end
          end else if (redir) begin
            // Request still in flight: remember to drop its data when it lands.
            discard_q <= 1'b1;
            pc_q      <= jp_pc;
          end
        end
        ST_HOLD: begin
          if (jp_e) begin
            if (jp_pc != '0) pc_q <= jp_pc;
            state_q <= ST_FETCH;
          end
        end
        default: begin
          // HALT: only reset leaves; jp_ack still follows jp_e.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_if_fq.sv
// Self-checking bench for pipe_if_fq: cycle table, directed corner cases,
// and a randomized run scored against a queue-based fetch model.
module tb_pipe_if_fq;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] BRW = 32'h00000063;
  localparam logic [31:0] JAL = 32'h0000006F;

  logic        clk, rst;
  logic        mem_re, mem_rack, inst_valid, inst_ready, jp_e, jp_ack, halt;
  logic [31:0] mem_addr, mem_data, inst, inst_pc, jp_pc;
  logic [1:0]  mem_rlen;
  logic [9:0]  bp_tag_q;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_if_fq #(
    .INST_L(32), .PC_L(32), .FQ_DEPTH(4), .PC_ENTRY(32'h0), .STALL_ON_CTRL(1)
  ) dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rlen(mem_rlen),
    .mem_rack(mem_rack), .mem_data(mem_data), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .jp_e(jp_e), .jp_pc(jp_pc),
    .jp_ack(jp_ack), .bp_tag_q(bp_tag_q), .halt(halt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        jp_e;
    logic [31:0] jp_pc;
    logic        rack;
    logic [31:0] data;
    logic        ready;
    logic        e_re;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ipc;
    logic        e_ack;
    logic [9:0]  e_tag;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  vec_t vt [13];
  ent_t mq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst low after two reset edges; caller releases it.
  task automatic do_reset();
    rst = 1'b0; mem_rack = 1'b0; mem_data = '0; inst_ready = 1'b0; jp_e = 1'b0; jp_pc = '0;
    step();
    step();
  endtask

  task automatic wait_req(input string nm, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (!mem_re && n < 20) begin
      step();
      n++;
    end
    if (!mem_re) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no mem_re within 20 cycles, want addr %0h", nm, exp_addr);
    end else begin
      chk(nm, mem_addr, exp_addr);
    end
  endtask

  task automatic ack(input logic [31:0] d);
    mem_rack = 1'b1; mem_data = d;
    step();
    mem_rack = 1'b0; mem_data = '0;
  endtask

  function automatic vec_t mk(input logic je, input logic [31:0] jpc, input logic rk,
                              input logic [31:0] d, input logic rdy, input logic ere,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                              input logic eack, input logic [9:0] etag);
    vec_t v;
    v.jp_e = je; v.jp_pc = jpc; v.rack = rk; v.data = d; v.ready = rdy;
    v.e_re = ere; v.e_addr = ea; v.e_vld = ev; v.e_ipc = ep; v.e_ack = eack; v.e_tag = etag;
    return v;
  endfunction

  initial begin
    int cnt;
    logic [31:0] exp_pc;
    logic was_req, pop_pend, rack_pend;
    int wcnt;
    logic [31:0] w;

    // Branch at 0x8 parks fetch in HOLD; redirect to 0x40 flushes and resumes.
    vt[0]  = mk(1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 1'b0, 10'h0);
    vt[1]  = mk(1'b0, 32'h0,  1'b1, NOP,   1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 1'b0, 10'h0);
    vt[2]  = mk(1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00, 1'b0, 10'h0);
    vt[3]  = mk(1'b0, 32'h0,  1'b1, NOP,   1'b0, 1'b0, 32'h04, 1'b1, 32'h00, 1'b0, 10'h0);
    vt[4]  = mk(1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 1'b0, 10'h0);
    vt[5]  = mk(1'b0, 32'h0,  1'b1, BRW,   1'b0, 1'b0, 32'h08, 1'b1, 32'h00, 1'b0, 10'h8);
    vt[6]  = mk(1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h00, 1'b0, 10'h8);
    vt[7]  = mk(1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h00, 1'b0, 10'h8);
    vt[8]  = mk(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h08, 1'b0, 32'h00, 1'b1, 10'h8);
    vt[9]  = mk(1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h00, 1'b0, 10'h8);
    vt[10] = mk(1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h00, 1'b0, 10'h8);
    vt[11] = mk(1'b0, 32'h0,  1'b1, NOP,   1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 10'h8);
    vt[12] = mk(1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 1'b0, 32'h00, 1'b0, 10'h8);

    // Reset values.
    do_reset();
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_rlen", mem_rlen, 3);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_jp_ack", jp_ack, 0);
    chk("rst_bp_tag", bp_tag_q, 0);
    chk("rst_halt", halt, 0);

    // Cycle-exact table.
    rst = 1'b1;
    for (int i = 0; i < 13; i++) begin
      jp_e = vt[i].jp_e; jp_pc = vt[i].jp_pc; mem_rack = vt[i].rack;
      mem_data = vt[i].data; inst_ready = vt[i].ready;
      step();
      chk($sformatf("tbl%0d_mem_re", i), mem_re, vt[i].e_re);
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("tbl%0d_inst_valid", i), inst_valid, vt[i].e_vld);
      chk($sformatf("tbl%0d_inst_pc", i), inst_pc, vt[i].e_ipc);
      chk($sformatf("tbl%0d_jp_ack", i), jp_ack, vt[i].e_ack);
      chk($sformatf("tbl%0d_bp_tag", i), bp_tag_q, vt[i].e_tag);
    end
    jp_e = 1'b0; jp_pc = '0; mem_rack = 1'b0; mem_data = '0; inst_ready = 1'b0;

    // Sequential stream, ack after 2 cycles, consumer always ready.
    do_reset();
    rst = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_req("seq_addr", 32'(i * 4));
      step();
      step();
      chk("seq_re_held", mem_re, 1);
      chk("seq_addr_held", mem_addr, 32'(i * 4));
      ack(NOP);
      chk("seq_re_drop", mem_re, 0);
      chk("seq_valid", inst_valid, 1);
      chk("seq_inst_pc", inst_pc, 32'(i * 4));
    end

    // Full queue stops fetch; one pop lets exactly one request out.
    do_reset();
    rst = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_req("fill_addr", 32'(i * 4));
      ack(NOP | 32'(i << 20));
    end
    cnt = 0;
    for (int i = 0; i < 6; i++) begin step(); if (mem_re) cnt++; end
    chk("full_no_req", cnt, 0);
    chk("full_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("pop_head_pc", inst_pc, 32'h4);
    wait_req("refill_addr", 32'h10);
    ack(NOP);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin step(); if (mem_re) cnt++; end
    chk("refill_one_req", cnt, 0);

    // Redirect while waiting at 0x20: stale data dropped, refetch at 0x100.
    do_reset();
    rst = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_req("pre_addr", 32'(i * 4));
      ack(NOP);
    end
    wait_req("wait20_addr", 32'h20);
    jp_e = 1'b1; jp_pc = 32'h100;
    step();
    jp_e = 1'b0; jp_pc = '0;
    chk("disc_jp_ack", jp_ack, 1);
    chk("disc_re_held", mem_re, 1);
    chk("disc_addr_held", mem_addr, 32'h20);
    step();
    chk("disc_jp_ack_off", jp_ack, 0);
    ack(32'h02000013);
    chk("disc_dropped", inst_valid, 0);
    wait_req("redir_addr", 32'h100);
    chk("disc_still_empty", inst_valid, 0);
    ack(NOP);
    chk("redir_valid", inst_valid, 1);
    chk("redir_inst_pc", inst_pc, 32'h100);

    // Redirect coinciding with mem_rack: word dropped, no discard left behind.
    do_reset();
    rst = 1'b1; inst_ready = 1'b0;
    wait_req("coin_addr0", 32'h0);
    jp_e = 1'b1; jp_pc = 32'h200; mem_rack = 1'b1; mem_data = NOP;
    step();
    jp_e = 1'b0; jp_pc = '0; mem_rack = 1'b0; mem_data = '0;
    chk("coin_dropped", inst_valid, 0);
    wait_req("coin_addr", 32'h200);
    ack(NOP);
    chk("coin_valid", inst_valid, 1);
    chk("coin_inst_pc", inst_pc, 32'h200);

    // Resume-only redirect in HOLD keeps queue, fetch continues at pc+4.
    do_reset();
    rst = 1'b1; inst_ready = 1'b0;
    wait_req("hold_addr0", 32'h0);
    ack(JAL);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin step(); if (mem_re) cnt++; end
    chk("hold_no_req", cnt, 0);
    jp_e = 1'b1; jp_pc = '0;
    step();
    jp_e = 1'b0;
    chk("resume_jp_ack", jp_ack, 1);
    wait_req("resume_addr", 32'h4);
    chk("resume_kept_valid", inst_valid, 1);
    chk("resume_kept_pc", inst_pc, 32'h0);
    chk("resume_kept_inst", inst, JAL);

    // Zero word at 0x0C halts; HALT ignores redirects but still acks.
    do_reset();
    rst = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_req("h_addr", 32'(i * 4));
      ack(NOP);
    end
    wait_req("h_addr_c", 32'hC);
    ack(32'h0);
    chk("halt_set", halt, 1);
    chk("halt_re", mem_re, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin step(); if (mem_re) cnt++; end
    chk("halt_no_req", cnt, 0);
    chk("halt_q_valid", inst_valid, 1);
    chk("halt_q_pc", inst_pc, 32'h0);
    jp_e = 1'b1; jp_pc = 32'h40;
    step();
    jp_e = 1'b0; jp_pc = '0;
    chk("halt_jp_ack", jp_ack, 1);
    step();
    chk("halt_jp_ack_off", jp_ack, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin step(); if (mem_re) cnt++; end
    chk("halt_redir_no_req", cnt, 0);
    chk("halt_sticky", halt, 1);
    chk("halt_no_flush", inst_valid, 1);
    do_reset();
    chk("halt_cleared", halt, 0);

    // Reset mid-request: late rack ignored, first request right after release.
    rst = 1'b1;
    wait_req("mid_addr0", 32'h0);
    rst = 1'b0;
    step();
    rst = 1'b1; mem_rack = 1'b1; mem_data = 32'hDEAD0013;
    step();
    mem_rack = 1'b0; mem_data = '0;
    chk("mid_rst_re", mem_re, 1);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_valid", inst_valid, 0);

    // Randomized: random ack delay and consumer stalls against a queue model.
    do_reset();
    rst = 1'b1;
    mq.delete();
    exp_pc = '0; was_req = 1'b0; wcnt = 0;
    for (int c = 0; c < 600; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      pop_pend  = (mq.size() > 0) && inst_ready;
      rack_pend = mem_rack;
      w = mem_data;
      step();
      if (pop_pend) void'(mq.pop_front());
      if (rack_pend) begin
        ent_t e;
        e.pc = exp_pc; e.w = w;
        mq.push_back(e);
        exp_pc = exp_pc + 32'd4;
        chk("rnd_overfill", mq.size() > 4, 0);
      end
      chk("rnd_valid", inst_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("rnd_inst_pc", inst_pc, mq[0].pc);
        chk("rnd_inst", inst, mq[0].w);
      end
      mem_rack = 1'b0; mem_data = '0;
      if (mem_re) begin
        if (!was_req) begin
          chk("rnd_req_addr", mem_addr, exp_pc);
          wcnt = $urandom_range(0, 3);
        end
        if (wcnt == 0) begin
          w = $urandom();
          w[6:0] = 7'h13;
          mem_rack = 1'b1; mem_data = w;
        end else begin
          wcnt--;
        end
      end
      was_req = mem_re;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
